// File: rtl/multi_edge_pkg.sv
// Shared types for the multi-channel edge detector: detect-mode encoding and
// the helper that decides whether a level transition is an event.
package multi_edge_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic mode_hit(edge_mode_e m, logic rise, logic fall);
        return (((m == EDGE_RISE) || (m == EDGE_BOTH)) && rise) ||
               (((m == EDGE_FALL) || (m == EDGE_BOTH)) && fall);
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One detector channel: 2-flop synchroniser, optional debounce filter
// (MULTI_EDGE_DEBOUNCE_EN), edge detect, sticky pend and saturating counter.
module edge_channel
    import multi_edge_pkg::*;
#(
    parameter int CNT_W = 8
`ifdef MULTI_EDGE_DEBOUNCE_EN
    , parameter int DB_CYCLES = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d,
    input  logic [MODE_W-1:0] mode,
    input  logic              clr,
    output logic              level,
    output logic              pulse,
    output logic              pend,
    output logic [CNT_W-1:0]  count
);

    logic s1;
    logic s2;
    logic level_q;
    logic prev_q;
    logic pulse_q;
    logic pend_q;
    logic [CNT_W-1:0] count_q;
    logic hit;

`ifdef MULTI_EDGE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic            filt;
    logic [DB_W-1:0] db_cnt;

    // filt follows s2 only after DB_CYCLES consecutive differing samples;
    // level then registers filt, so latency grows by exactly DB_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt   <= 1'b0;
            db_cnt <= '0;
        end else if (s2 != filt) begin
            if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                filt   <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            s1      <= d;
            s2      <= s1;
`ifdef MULTI_EDGE_DEBOUNCE_EN
            level_q <= filt;
`else
            level_q <= s2;
`endif
            prev_q  <= level_q;
        end
    end

    always_comb begin
        hit = mode_hit(edge_mode_e'(mode), level_q & ~prev_q, ~level_q & prev_q);
    end

    // An event in the same cycle as clr wins: pend stays set, count restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
            count_q <= '0;
        end else begin
            pulse_q <= hit;
            if (hit) begin
                pend_q <= 1'b1;
                if (clr) begin
                    count_q <= CNT_W'(1);
                end else if (count_q != '1) begin
                    count_q <= count_q + 1'b1;
                end
            end else if (clr) begin
                pend_q  <= 1'b0;
                count_q <= '0;
            end
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;
    assign pend  = pend_q;
    assign count = count_q;

endmodule

// File: rtl/multi_edge_detector.sv
// NCH independent edge-detect channels with sticky pend flags, event counters
// and an OR-reduced irq; debounce is compiled in by MULTI_EDGE_DEBOUNCE_EN.
module multi_edge_detector
    import multi_edge_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         d,
    input  logic [MODE_W*NCH-1:0]  mode,
    input  logic [NCH-1:0]         clr,
    output logic [NCH-1:0]         level,
    output logic [NCH-1:0]         pulse,
    output logic [NCH-1:0]         pend,
    output logic [NCH*CNT_W-1:0]   count,
    output logic                   irq
);

    if ((NCH < 1) || (NCH > 32) || (CNT_W < 1) || (DB_CYCLES < 1)) begin : g_param_check
        $error("multi_edge_detector: parameter out of range");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_channel #(
            .CNT_W(CNT_W)
`ifdef MULTI_EDGE_DEBOUNCE_EN
            , .DB_CYCLES(DB_CYCLES)
`endif
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d[i]),
            .mode  (mode[MODE_W*i +: MODE_W]),
            .clr   (clr[i]),
            .level (level[i]),
            .pulse (pulse[i]),
            .pend  (pend[i]),
            .count (count[CNT_W*i +: CNT_W])
        );
    end

    assign irq = |pend;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed scoreboard bench for multi_edge_detector (NCH=4, CNT_W=2, DB_CYCLES=4).
module tb_multi_edge_detector;

    localparam int NCH   = 4;
    localparam int CNT_W = 2;
`ifdef MULTI_EDGE_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    logic               clk;
    logic               rst_n;
    logic [NCH-1:0]     d;
    logic [2*NCH-1:0]   mode;
    logic [NCH-1:0]     clr;
    logic [NCH-1:0]     level;
    logic [NCH-1:0]     pulse;
    logic [NCH-1:0]     pend;
    logic [NCH*CNT_W-1:0] count;
    logic               irq;

    int tests;
    int failed;

    typedef struct {
        string          tag;
        logic [NCH-1:0] level;
        logic [NCH-1:0] pulse;
        logic [NCH-1:0] pend;
        logic [NCH*CNT_W-1:0] count;
        logic           irq;
    } exp_t;

    exp_t sb[$];

    multi_edge_detector #(
        .NCH(NCH),
        .DB_CYCLES(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .mode  (mode),
        .clr   (clr),
        .level (level),
        .pulse (pulse),
        .pend  (pend),
        .count (count),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [NCH-1:0] lv, input logic [NCH-1:0] pu,
                              input logic [NCH-1:0] pe, input logic [NCH*CNT_W-1:0] c, input logic i);
        exp_t e;
        e.tag = tag; e.level = lv; e.pulse = pu; e.pend = pe; e.count = c; e.irq = i;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".level"}, 32'(level), 32'(e.level));
            chk({e.tag, ".pulse"}, 32'(pulse), 32'(e.pulse));
            chk({e.tag, ".pend"},  32'(pend),  32'(e.pend));
            chk({e.tag, ".count"}, 32'(count), 32'(e.count));
            chk({e.tag, ".irq"},   32'(irq),   32'(e.irq));
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        d      = '0;
        mode   = '0;
        clr    = '0;

        // reset state
        expect_out("reset", 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick(2);
        check_out();
        rst_n = 1'b1;
        tick(2);

        // ch0 rise: level at +2, pulse at +3 for one cycle
        mode = 8'b00_00_00_01;
        d    = 4'b0001;
        expect_out("rise0_lvl", 4'b0001, 4'b0000, 4'b0000, 8'b00_00_00_00, 1'b0);
        tick(3 + LAT);
        check_out();
        expect_out("rise0_pulse", 4'b0001, 4'b0001, 4'b0001, 8'b00_00_00_01, 1'b1);
        tick(1);
        check_out();
        expect_out("rise0_after", 4'b0001, 4'b0000, 4'b0001, 8'b00_00_00_01, 1'b1);
        tick(1);
        check_out();

        // ch1 fall-only: rise ignored, fall counted
        mode = 8'b00_00_10_01;
        d    = 4'b0011;
        expect_out("fall1_rise_ign", 4'b0011, 4'b0000, 4'b0001, 8'b00_00_00_01, 1'b1);
        tick(4 + LAT);
        check_out();
        tick(6);
        d = 4'b0001;
        expect_out("fall1_lvl", 4'b0001, 4'b0000, 4'b0001, 8'b00_00_00_01, 1'b1);
        tick(3 + LAT);
        check_out();
        expect_out("fall1_pulse", 4'b0001, 4'b0010, 4'b0011, 8'b00_00_01_01, 1'b1);
        tick(1);
        check_out();
        tick(1);

        // plain clear of ch1, then both-edge mode counts rise and fall
        mode = 8'b00_00_11_01;
        clr  = 4'b0010;
        expect_out("clr1", 4'b0001, 4'b0000, 4'b0001, 8'b00_00_00_01, 1'b1);
        tick(1);
        clr = 4'b0000;
        check_out();
        d = 4'b0011;
        tick(10);
        d = 4'b0001;
        expect_out("both1", 4'b0001, 4'b0000, 4'b0011, 8'b00_00_10_01, 1'b1);
        tick(10);
        check_out();

        // ch2 off: level tracks, no event
        d = 4'b0101;
        expect_out("off2", 4'b0101, 4'b0000, 4'b0011, 8'b00_00_10_01, 1'b1);
        tick(5 + LAT);
        check_out();
        d = 4'b0001;
        tick(5 + LAT);

        // ch3 saturation at 3, then clr coincident with 6th event
        mode = 8'b01_00_11_01;
        for (int k = 0; k < 5; k++) begin
            d = 4'b1001;
            tick(5 + LAT);
            d = 4'b0001;
            tick(5 + LAT);
        end
        expect_out("sat3", 4'b0001, 4'b0000, 4'b1011, 8'b11_00_10_01, 1'b1);
        check_out();
        d = 4'b1001;
        tick(3 + LAT);
        clr = 4'b1000;
        expect_out("clr_event3", 4'b1001, 4'b1000, 4'b1011, 8'b01_00_10_01, 1'b1);
        tick(1);
        clr = 4'b0000;
        check_out();
        tick(1);

        // simultaneous events on all channels, then partial clear
        mode = 8'hFF;
        clr  = 4'b1111;
        expect_out("clr_all", 4'b1001, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick(1);
        clr = 4'b0000;
        check_out();
        d = 4'b0110;
        expect_out("simul_lvl", 4'b0110, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick(3 + LAT);
        check_out();
        expect_out("simul_pulse", 4'b0110, 4'b1111, 4'b1111, 8'b01_01_01_01, 1'b1);
        tick(1);
        check_out();
        clr = 4'b0101;
        expect_out("clr_0101", 4'b0110, 4'b0000, 4'b1010, 8'b01_00_01_00, 1'b1);
        tick(1);
        clr = 4'b0000;
        check_out();

`ifdef MULTI_EDGE_DEBOUNCE_EN
        // 3-cycle glitch on ch2 is filtered; an 8-cycle hold passes once
        d = 4'b0010;
        tick(10);
        clr = 4'b1111;
        tick(1);
        clr = 4'b0000;
        d = 4'b0110;
        tick(3);
        d = 4'b0010;
        expect_out("glitch2", 4'b0010, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick(12);
        check_out();
        d = 4'b0110;
        expect_out("db_pass2", 4'b0110, 4'b0100, 4'b0100, 8'b00_01_00_00, 1'b1);
        tick(4 + LAT);
        check_out();
        tick(2);
`endif

        // reset mid-pulse aborts everything immediately
        d = d | 4'b0001;
        tick(3 + LAT);
        #2;
        rst_n = 1'b0;
        d     = 4'b0000;
        expect_out("async_rst", 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
        #1;
        check_out();
        tick(2);
        rst_n = 1'b1;
        expect_out("post_rst_quiet", 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick(10 + LAT);
        check_out();

        // d high through reset release gives a normal rise event
        rst_n = 1'b0;
        d     = 4'b0001;
        tick(2);
        rst_n = 1'b1;
        expect_out("rst_hi_lvl", 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick(3 + LAT);
        check_out();
        expect_out("rst_hi_pulse", 4'b0001, 4'b0001, 4'b0001, 8'b00_00_00_01, 1'b1);
        tick(1);
        check_out();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter NCH, default 4, number of independent input channels (1..32).
REQ-002 Parameter DB_CYCLES, default 4, debounce stability window in cycles (>=1; used only with debounce compiled in).
REQ-003 Parameter CNT_W, default 8, width of each per-channel event counter (>=1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 d  input  NCH  raw asynchronous channel inputs.
REQ-007 mode  input  2*NCH  per-channel detect mode, channel i at bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 clr  input  NCH  per-channel clear of pend and count.
REQ-009 level  output  NCH  synchronised (and filtered) level of each channel.
REQ-010 pulse  output  NCH  registered single-cycle event strobe per channel.
REQ-011 pend  output  NCH  sticky pending-event flag per channel.
REQ-012 count  output  NCH*CNT_W  per-channel event counters, channel i at bits [(i+1)*CNT_W-1:i*CNT_W].
REQ-013 irq  output  1  OR-reduction of pend.

Function
REQ-014 Each d[i] SHALL pass through a two-flop synchroniser; the synchronised value is s[i].
REQ-015 Without debounce, level[i] SHALL register s[i] every cycle, so a d change settled before edge k appears on level at edge k+2.
REQ-016 A rise event SHALL be level[i] 0->1 and a fall event level[i] 1->0, detected against a registered previous level.
REQ-017 pulse[i] SHALL be high for exactly one cycle, on the edge following a level transition that matches mode[i]; with debounce off, total latency from d change to pulse is 3 edges.
REQ-018 A transition whose direction does not match mode[i], or any transition with mode 00, SHALL produce no pulse, no pend and no count change; level still tracks.
REQ-019 A mode change SHALL take effect for transitions detected on or after the edge following the change; no retroactive events.
REQ-020 pend[i] SHALL set on the edge pulse[i] rises and hold until clr[i].
REQ-021 count[i] SHALL increment by 1 per event and saturate at 2^CNT_W-1 (no wrap).
REQ-022 clr[i] SHALL zero pend[i] and count[i] on the next edge; if an event occurs in that same cycle, the event wins: pend[i]=1, count[i]=1.
REQ-023 irq SHALL be combinational OR of pend; no cycle of delay.
REQ-024 Channels SHALL be fully independent; simultaneous events on any channel subset are all captured in the same cycle.

Reset
REQ-025 rst_n low SHALL asynchronously clear synchroniser flops, level, previous level, debounce counters, pulse, pend and count to 0; irq is therefore 0.
REQ-026 A d[i] held high through reset release SHALL yield a rise event (if mode allows) once propagated, exactly as a normal 0->1 transition.
REQ-027 Reset asserted mid-debounce or mid-pulse SHALL abort it; no event is produced after release from pre-reset activity.

Configuration
REQ-028 Macro MULTI_EDGE_DEBOUNCE_EN SHALL, when defined, insert a per-channel debounce filter: level[i] takes s[i] only after s[i] differs from level[i] for DB_CYCLES consecutive cycles; any intermediate return to level[i] restarts the window; latency grows by DB_CYCLES.
REQ-029 Without MULTI_EDGE_DEBOUNCE_EN, no debounce counters SHALL be synthesised and REQ-015 timing applies; DB_CYCLES is ignored.

Structure
REQ-030 Package multi_edge_pkg SHALL hold the mode typedef (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and the mode-field width constant.
REQ-031 One sub-module edge_channel SHALL implement a single channel (synchroniser, optional debounce, detect, pend, count) and be instantiated NCH times by a generate loop.

Verification
REQ-032 Debounce off, mode[0]=01, d[0] 0->1 -> level[0]=1 at edge +2, pulse[0]=1 for one cycle at edge +3, pend[0]=1, count[0]=1, irq=1.
REQ-033 mode[1]=10, d[1] toggles 0->1->0 (10 cycles apart) -> only the fall yields a pulse; count[1]=1; mode 11 on the same stimulus -> count=2.
REQ-034 Debounce on, DB_CYCLES=4, glitch on d[2] high for 3 cycles -> no level change, no pulse; held 4+ cycles -> one pulse.
REQ-035 CNT_W=2, 5 rise events on channel 3 -> count[3] sticks at 3; clr[3] asserted in the same cycle as a 6th event -> pend[3]=1, count[3]=1.
REQ-036 Events on channels 0..3 in the same cycle -> all four pulse bits high together; clr=4'b0101 -> pend=4'b1010, irq stays 1.
REQ-037 rst_n pulled low asynchronously mid-debounce with pend set -> all outputs 0 immediately; no pulse after release while d remains unchanged low.
